// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream skid buffer: state enums and beat packing.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
`ifndef AXIS_PKG_SV
`define AXIS_PKG_SV

// Beat layout {tdata, tlast, tuser}. This is a macro rather than a package
// typedef because the field widths come from the instantiating module's
// parameters.
`define AXIS_BEAT_STRUCT(BYTES, UBITS) \
    struct packed { \
        logic [(BYTES)*8-1:0] tdata; \
        logic                 tlast; \
        logic [(UBITS)-1:0]   tuser; \
    }

package axis_pkg;

    // States for the zero-latency variant. PASS means the skid slot is empty.
    typedef enum logic [1:0] {
        S_PASS = 2'd0,
        S_SKID = 2'd1
    } skid_state_e;

    // States for the full register slice. The name is the number of beats held.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } fwd_state_e;

endpackage

`endif

// File: rtl/axis_skid_slot.sv
// One-beat storage register with a load enable. It has no reset.
// Latency: 1 cycle from ld_i to q_o.
// Backpressure: none. The caller decides when to load.
// Ports: clk, ld_i (load strobe), d_i (beat in), q_o (stored beat).
module axis_skid_slot #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/axis_skid_buffer.sv
// AXI-Stream reverse-path register slice. A one-entry skid store keeps tready registered.
// Latency: 0 cycles by default. With AXIS_SKID_FWD_REG_EN defined it is 1 cycle (full slice).
// Backpressure: axis_i_tready is a flop output. It drops only once a beat has been stored.
// Ports: clk/sresetn (synchronous reset, active low); axis_i_* upstream; axis_o_* downstream;
//        skid_full reports that the skid slot is occupied.
// Config macro: AXIS_SKID_FWD_REG_EN also registers tvalid/tdata/tlast/tuser.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1
) (
    input  logic                      clk,
    input  logic                      sresetn,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tvalid,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
    output logic                      skid_full
);

    typedef `AXIS_BEAT_STRUCT(AXIS_BYTES, AXIS_USER_BITS) beat_t;
    localparam int BW = $bits(beat_t);

    beat_t in_beat, skid_beat, out_beat;
    logic  skid_ld;
    logic  tready_q, tready_d;
    logic  in_fire;

    assign in_beat = '{tdata: axis_i_tdata, tlast: axis_i_tlast, tuser: axis_i_tuser};
    assign in_fire = axis_i_tvalid && tready_q;

    axis_skid_slot #(.W(BW)) u_skid (
        .clk  (clk),
        .ld_i (skid_ld),
        .d_i  (in_beat),
        .q_o  (skid_beat)
    );

`ifdef AXIS_SKID_FWD_REG_EN
    fwd_state_e state_q, state_d;
    logic       out_ld, out_from_skid, out_fire;
    beat_t      out_d;

    // The output stage is loaded from the input, or from the skid slot while it drains.
    assign out_d = out_from_skid ? skid_beat : in_beat;

    axis_skid_slot #(.W(BW)) u_out (
        .clk  (clk),
        .ld_i (out_ld),
        .d_i  (out_d),
        .q_o  (out_beat)
    );

    assign out_fire = (state_q != S_EMPTY) && axis_o_tready;

    always_comb begin
        state_d       = state_q;
        out_ld        = 1'b0;
        out_from_skid = 1'b0;
        skid_ld       = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    out_ld  = 1'b1;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    out_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_d = S_TWO;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // tready is low here, so the only movement is skid -> output.
                if (out_fire) begin
                    out_ld        = 1'b1;
                    out_from_skid = 1'b1;
                    state_d       = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign tready_d      = (state_d != S_TWO);
    assign axis_o_tvalid = (state_q != S_EMPTY);
    assign skid_full     = (state_q == S_TWO);

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q  <= S_EMPTY;
            tready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
        end
    end
`else
    skid_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        skid_ld = 1'b0;
        case (state_q)
            S_PASS: begin
                // The beat was accepted upstream but cannot leave, so park it.
                if (in_fire && !axis_o_tready) begin
                    skid_ld = 1'b1;
                    state_d = S_SKID;
                end
            end
            S_SKID: begin
                if (axis_o_tready) begin
                    state_d = S_PASS;
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    // tready_q comes from the next state, never straight from axis_o_tready.
    assign tready_d      = (state_d == S_PASS);
    assign out_beat      = (state_q == S_SKID) ? skid_beat : in_beat;
    assign axis_o_tvalid = (state_q == S_SKID) ? 1'b1 : axis_i_tvalid;
    assign skid_full     = (state_q == S_SKID);

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q  <= S_PASS;
            tready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
        end
    end
`endif

    assign axis_i_tready = tready_q;
    assign axis_o_tdata  = out_beat.tdata;
    assign axis_o_tlast  = out_beat.tlast;
    assign axis_o_tuser  = out_beat.tuser;

endmodule

// File: tb/tb_axis_skid_buffer.sv
// Self-checking bench for axis_skid_buffer. A FIFO model tracks the beats held inside the DUT.
// Latency: checks zero-latency pass-through, or 1-cycle latency with AXIS_SKID_FWD_REG_EN.
// Backpressure: random and patterned downstream stalls; upstream holds each beat until accepted.
module tb_axis_skid_buffer;

    logic       clk = 1'b0;
    logic       sresetn;
    logic       axis_i_tready;
    logic       axis_i_tvalid;
    logic       axis_i_tlast;
    logic [7:0] axis_i_tdata;
    logic [0:0] axis_i_tuser;
    logic       axis_o_tready;
    logic       axis_o_tvalid;
    logic       axis_o_tlast;
    logic [7:0] axis_o_tdata;
    logic [0:0] axis_o_tuser;
    logic       skid_full;

    always #5 clk = ~clk;

    axis_skid_buffer #(.AXIS_BYTES(1), .AXIS_USER_BITS(1)) dut (
        .clk           (clk),
        .sresetn       (sresetn),
        .axis_i_tready (axis_i_tready),
        .axis_i_tvalid (axis_i_tvalid),
        .axis_i_tlast  (axis_i_tlast),
        .axis_i_tdata  (axis_i_tdata),
        .axis_i_tuser  (axis_i_tuser),
        .axis_o_tready (axis_o_tready),
        .axis_o_tvalid (axis_o_tvalid),
        .axis_o_tlast  (axis_o_tlast),
        .axis_o_tdata  (axis_o_tdata),
        .axis_o_tuser  (axis_o_tuser),
        .skid_full     (skid_full)
    );

    // Storage capacity of the DUT. With forward registering it is the output stage plus the skid slot.
`ifdef AXIS_SKID_FWD_REG_EN
    localparam int  CAP = 2;
    localparam bit  FWD = 1'b1;
`else
    localparam int  CAP = 1;
    localparam bit  FWD = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [0:0] u;
    } beat_t;

    // Reference model: q holds the beats accepted but not yet delivered, oldest first.
    beat_t q[$];
    beat_t vis[$];
    beat_t ib, ob;
    bit    in_fired = 1'b0;
    bit    mon_en   = 1'b1;
    int    out_cnt  = 0;
    int    a5_cnt   = 0;
    bit    exp_vld;

    always @(negedge clk) begin
        in_fired = 1'b0;
        if (!sresetn) begin
            q.delete();
        end else if (mon_en) begin
            check_eq("i_tready", axis_i_tready, q.size() < CAP);
            check_eq("skid_full", skid_full, q.size() == CAP);
            vis = q;
            ib  = '{d: axis_i_tdata, l: axis_i_tlast, u: axis_i_tuser};
            in_fired = axis_i_tvalid && axis_i_tready;
            if (in_fired) vis.push_back(ib);
            // Without forward registering, a beat accepted this cycle is visible at once.
            exp_vld = FWD ? (q.size() > 0) : (vis.size() > 0);
            check_eq("o_tvalid", axis_o_tvalid, exp_vld);
            ob = '{d: axis_o_tdata, l: axis_o_tlast, u: axis_o_tuser};
            if (axis_o_tvalid && vis.size() > 0) begin
                check_eq("o_beat", ob, vis[0]);
                if (axis_o_tready) void'(vis.pop_front());
            end
            if (axis_o_tvalid && axis_o_tready) begin
                out_cnt++;
                if (axis_o_tdata == 8'hA5) a5_cnt++;
            end
            if (vis.size() > CAP) check_eq("occupancy", vis.size(), CAP);
            q = vis;
        end
    end

    int seq = 0;

    // One cycle of upstream/downstream stimulus. A pending beat is held until it is accepted.
    task automatic step(input int vprob, input int rprob);
        @(posedge clk);
        #1;
        if (!(axis_i_tvalid && !in_fired)) begin
            if ($urandom_range(99) < vprob) begin
                axis_i_tvalid = 1'b1;
                axis_i_tdata  = seq[7:0];
                axis_i_tlast  = (seq % 8) == 7;
                axis_i_tuser  = seq[0];
                seq++;
            end else begin
                axis_i_tvalid = 1'b0;
            end
        end
        axis_o_tready = ($urandom_range(99) < rprob);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        sresetn       = 1'b0;
        axis_i_tvalid = 1'b0;
        axis_o_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sresetn = 1'b1;
    endtask

    int c0, start, cyc;

    initial begin
        sresetn       = 1'b0;
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
        axis_i_tdata  = 8'h00;
        axis_i_tuser  = 1'b0;
        axis_o_tready = 1'b0;
        do_reset();
        @(negedge clk);
        #1;
        check_eq("rst_i_tready", axis_i_tready, 1);
        check_eq("rst_o_tvalid", axis_o_tvalid, 0);
        check_eq("rst_skid_full", skid_full, 0);

        // Test 1: stream 0x00..0x0F with downstream always ready.
        seq = 0;
        c0  = out_cnt;
        while (seq < 16) step(100, 100);
        repeat (4) step(0, 100);
        @(negedge clk);
        #1;
        check_eq("t1_count", out_cnt - c0, 16);

        // Test 2: beat 0xA5 stalls for 5 cycles, then leaves exactly once.
        a5_cnt = 0;
        seq    = 8'hA5;
        step(100, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            @(negedge clk);
            #1;
            check_eq("t2_hold_vld", axis_o_tvalid, 1);
            check_eq("t2_hold_dat", axis_o_tdata, 8'hA5);
            check_eq("t2_i_tready", axis_i_tready, FWD);
        end
        repeat (4) step(0, 100);
        @(negedge clk);
        #1;
        check_eq("t2_a5_once", a5_cnt, 1);

        // Test 3: 1000 beats with random valid and ready.
        seq   = 0;
        start = out_cnt;
        cyc   = 0;
        while (seq < 1000 && cyc < 5000) begin
            step(70, 50);
            cyc++;
        end
        check_eq("t3_budget", seq, 1000);
        repeat (6) step(0, 100);
        @(negedge clk);
        #1;
        check_eq("t3_count", out_cnt - start, seq);
        check_eq("t3_drained", q.size(), 0);

        // Test 4: downstream toggles every cycle while input is always valid.
        c0 = out_cnt;
        for (int i = 0; i < 40; i++) step(100, (i % 2 == 0) ? 100 : 0);
        @(negedge clk);
        #1;
        check_eq("t4_thru", (out_cnt - c0) >= 19, 1);
        repeat (6) step(0, 100);

        // Test 5: reset while the skid slot holds 0x3C; the beat must vanish.
        cyc = 0;
        while (!skid_full && cyc < 10) begin
            seq = 8'h3C;
            step(100, 0);
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("t5_skid_full", skid_full, 1);
        do_reset();
        @(negedge clk);
        #1;
        check_eq("t5_o_tvalid", axis_o_tvalid, 0);
        check_eq("t5_i_tready", axis_i_tready, 1);
        c0 = out_cnt;
        repeat (5) step(0, 100);
        @(negedge clk);
        #1;
        check_eq("t5_no_emit", out_cnt - c0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
